// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared types and constants for the load/store data memory.
//   size_e       : access size codes carried on req_size
//   state_e      : request FSM states
//   req_ctrl_t   : request fields captured at the accept edge (address kept
//                  separately because its width is a module parameter)
//   WAIT_CNT_W   : width of the wait-state counter (supports 0..15 wait states)
// -----------------------------------------------------------------------------
package dmem_pkg;

    localparam int WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_RSVD = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic        write;
        size_e       size;
        logic        is_unsigned;
        logic [31:0] wdata;
    } req_ctrl_t;

endpackage

// File: rtl/dmem_lane_align.sv
// -----------------------------------------------------------------------------
// dmem_lane_align
// Purely combinational byte-lane steering between a 32-bit memory word and
// the right-aligned request/response data.
//   size        in  : access size (byte/half/word/reserved)
//   off         in  : req_addr[1:0]
//   is_unsigned in  : loads zero-extend when set, sign-extend otherwise
//   wdata       in  : right-aligned store data
//   rword       in  : current contents of the addressed word
//   be          out : byte-lane write enables (0 for reserved size)
//   wdata_lane  out : store data replicated onto every lane; be picks the lanes
//   rdata_ext   out : selected lane(s), extended to 32 bits
//   misalign    out : access violates natural alignment and must trap
// Configuration macro: DMEM_MISALIGN_TRAP_EN
//   defined   -> misalign flags half accesses with off[0]=1 and word accesses
//                with off!=0
//   undefined -> misalign is tied low; offending offset bits are ignored so
//                the access lands on the aligned half/word
// -----------------------------------------------------------------------------
module dmem_lane_align
    import dmem_pkg::*;
(
    input  size_e       size,
    input  logic [1:0]  off,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext,
    output logic        misalign
);

    logic [1:0]  eff_off;
    logic [31:0] shifted;

    // Low offset bits that cannot address a naturally aligned lane group are
    // dropped; with trapping enabled such accesses never reach the array.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        eff_off = 2'b00;
        unique case (size)
            SZ_BYTE: eff_off = off;
            SZ_HALF: eff_off = {off[1], 1'b0};
            default: eff_off = 2'b00;
        endcase
    end

    always_comb begin
        be         = 4'b0000;
        wdata_lane = 32'h0;
        unique case (size)
            SZ_BYTE: begin
                be         = 4'b0001 << eff_off;
                wdata_lane = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                be         = 4'b0011 << eff_off;
                wdata_lane = {2{wdata[15:0]}};
            end
            SZ_WORD: begin
                be         = 4'b1111;
                wdata_lane = wdata;
            end
            default: begin
                be         = 4'b0000;
                wdata_lane = 32'h0;
            end
        endcase
    end

    assign shifted = rword >> {eff_off, 3'b000};

    always_comb begin
        rdata_ext = 32'h0;
        unique case (size)
            SZ_BYTE: rdata_ext = is_unsigned ? {24'h0, shifted[7:0]}
                                             : {{24{shifted[7]}}, shifted[7:0]};
            SZ_HALF: rdata_ext = is_unsigned ? {16'h0, shifted[15:0]}
                                             : {{16{shifted[15]}}, shifted[15:0]};
            SZ_WORD: rdata_ext = rword;
            default: rdata_ext = 32'h0;
        endcase
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misalign = ((size == SZ_HALF) && off[0]) ||
                      ((size == SZ_WORD) && (off != 2'b00));
`else
    assign misalign = 1'b0;
`endif

endmodule

// File: rtl/data_memory_ls.sv
// -----------------------------------------------------------------------------
// data_memory_ls
// Load/store data memory for the RISC-V datapath. Byte/half/word loads and
// stores with sign/zero extension, a valid/ready request port, a registered
// one-cycle response pulse and a programmable number of wait states.
// Parameters:
//   DEPTH_WORDS : number of 32-bit words (word index = req_addr[ADDR_W-1:2])
//   ADDR_W      : byte-address width
//   WAIT_STATES : extra cycles between accept and response (0..15)
// Ports:
//   clock, reset_n            : clock, asynchronous active-low reset
//   req_valid / req_ready     : request handshake, transfer on posedge when both high
//   req_write                 : 1 = store, 0 = load
//   req_size                  : 0 byte, 1 half, 2 word, 3 reserved (faults)
//   req_unsigned              : loads zero-extend when set
//   req_addr                  : byte address
//   req_wdata                 : right-aligned store data
//   rsp_valid                 : one-cycle response pulse
//   rsp_rdata                 : extended load data, 0 for stores and faults
//   rsp_fault                 : out of range, reserved size, or trapped misalign
// Configuration macro: DMEM_MISALIGN_TRAP_EN (see dmem_lane_align)
// -----------------------------------------------------------------------------
module data_memory_ls
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 512,
    parameter int ADDR_W      = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_fault
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
        WAIT_CNT_W'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);
    localparam logic [ADDR_W-3:0] DEPTH_LIMIT = (ADDR_W-2)'(DEPTH_WORDS);

    state_e                  state, state_nxt;
    logic [WAIT_CNT_W-1:0]   wait_cnt;
    req_ctrl_t               lat_ctrl;
    logic [ADDR_W-1:0]       lat_addr;

    req_ctrl_t               live_ctrl;
    req_ctrl_t               op_ctrl;
    logic [ADDR_W-1:0]       op_addr;
    logic                    accept;
    logic                    commit;

    logic [ADDR_W-3:0]       word_idx;
    logic [IDX_W-1:0]        mem_idx;
    logic                    in_range;
    logic                    op_fault;
    logic                    do_write;

    logic [3:0]              be;
    logic [31:0]             wdata_lane;
    logic [31:0]             rdata_ext;
    logic [31:0]             rword;
    logic                    misalign;

    logic [31:0]             mem [DEPTH_WORDS];

    // ------------------------------------------------------------------
    // Handshake and operand selection
    // ------------------------------------------------------------------
    assign req_ready = (state != WAIT);
    assign accept    = req_valid && req_ready;

    always_comb begin
        live_ctrl             = '0;
        live_ctrl.write       = req_write;
        live_ctrl.size        = size_e'(req_size);
        live_ctrl.is_unsigned = req_unsigned;
        live_ctrl.wdata       = req_wdata;
    end

    // With zero wait states the array is touched on the accept edge itself,
    // so the live request is used; otherwise the latched copy is used while
    // the WAIT state runs out.
    assign op_ctrl = (state == WAIT) ? lat_ctrl : live_ctrl;
    assign op_addr = (state == WAIT) ? lat_addr : req_addr;

    // The edge that enters RESP is the one that commits the access.
    assign commit = (state == WAIT) ? (wait_cnt == '0)
                                    : (accept && (WAIT_STATES == 0));

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block ordering.
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, RESP: begin
                if (accept) begin
                    state_nxt = (WAIT_STATES > 0) ? WAIT : RESP;
                end else begin
                    state_nxt = IDLE;
                end
            end
            WAIT: begin
                if (wait_cnt == '0) begin
                    state_nxt = RESP;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= '0;
        end else if (accept && (WAIT_STATES > 0)) begin
            wait_cnt <= WAIT_LOAD;
        end else if ((state == WAIT) && (wait_cnt != '0)) begin
            wait_cnt <= wait_cnt - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lat_ctrl <= '0;
            lat_addr <= '0;
        end else if (accept) begin
            lat_ctrl <= live_ctrl;
            lat_addr <= req_addr;
        end
    end

    // ------------------------------------------------------------------
    // Address decode and lane steering
    // ------------------------------------------------------------------
    assign word_idx = op_addr[ADDR_W-1:2];
    assign mem_idx  = word_idx[IDX_W-1:0];
    assign in_range = (word_idx < DEPTH_LIMIT);
    assign rword    = mem[mem_idx];

    dmem_lane_align u_lane_align (
        .size        (op_ctrl.size),
        .off         (op_addr[1:0]),
        .is_unsigned (op_ctrl.is_unsigned),
        .wdata       (op_ctrl.wdata),
        .rword       (rword),
        .be          (be),
        .wdata_lane  (wdata_lane),
        .rdata_ext   (rdata_ext),
        .misalign    (misalign)
    );

    assign op_fault = (op_ctrl.size == SZ_RSVD) || !in_range || misalign;
    assign do_write = commit && op_ctrl.write && !op_fault;

    // ------------------------------------------------------------------
    // Storage array
    // ------------------------------------------------------------------
    // NOTE: the array has no reset; clearing it would force a flop-based
    // implementation and software must not rely on initial contents anyway.
    always_ff @(posedge clock) begin
        for (int i = 0; i < 4; i++) begin
            if (do_write && be[i]) begin
                mem[mem_idx][8*i +: 8] <= wdata_lane[8*i +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_fault <= 1'b0;
        end else begin
            rsp_valid <= commit;
            if (commit) begin
                rsp_fault <= op_fault;
                rsp_rdata <= (op_ctrl.write || op_fault) ? 32'h0 : rdata_ext;
            end
        end
    end

endmodule

// File: tb/tb_data_memory_ls.sv
// -----------------------------------------------------------------------------
// tb_data_memory_ls
// Three instances of data_memory_ls sharing one clock:
//   instance 0 : WAIT_STATES = 0 (vector table, back-to-back traffic)
//   instance 1 : WAIT_STATES = 3 (ready/response latency)
//   instance 2 : WAIT_STATES = 2 (reset while a store is waiting)
// Expected responses are queued per instance when a request is accepted and
// compared when rsp_valid is seen. DMEM_MISALIGN_TRAP_EN selects the expected
// results of the misaligned vectors.
// -----------------------------------------------------------------------------
module tb_data_memory_ls;
    import dmem_pkg::*;

    localparam int NDUT = 3;

    typedef struct {
        logic        write;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_fault;
    } vec_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        fault;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n      [NDUT];
    logic        req_valid    [NDUT];
    logic        req_ready    [NDUT];
    logic        req_write    [NDUT];
    logic [1:0]  req_size     [NDUT];
    logic        req_unsigned [NDUT];
    logic [31:0] req_addr     [NDUT];
    logic [31:0] req_wdata    [NDUT];
    logic        rsp_valid    [NDUT];
    logic [31:0] rsp_rdata    [NDUT];
    logic        rsp_fault    [NDUT];

    exp_t sb [NDUT][$];
    vec_t vecs[$];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        data_memory_ls #(
            .DEPTH_WORDS (512),
            .ADDR_W      (32),
            .WAIT_STATES ((g == 0) ? 0 : (g == 1) ? 3 : 2)
        ) u_dut (
            .clock        (clock),
            .reset_n      (reset_n[g]),
            .req_valid    (req_valid[g]),
            .req_ready    (req_ready[g]),
            .req_write    (req_write[g]),
            .req_size     (req_size[g]),
            .req_unsigned (req_unsigned[g]),
            .req_addr     (req_addr[g]),
            .req_wdata    (req_wdata[g]),
            .rsp_valid    (rsp_valid[g]),
            .rsp_rdata    (rsp_rdata[g]),
            .rsp_fault    (rsp_fault[g])
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: bound expired", name);
    endtask

    function automatic vec_t mk(input logic w, input logic [1:0] sz, input logic u,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] rd, input logic f);
        vec_t v;
        v.write = w; v.size = sz; v.uns = u; v.addr = a; v.wdata = wd;
        v.exp_rdata = rd; v.exp_fault = f;
        return v;
    endfunction

    // Response monitor / scoreboard
    always @(negedge clock) begin
        for (int d = 0; d < NDUT; d++) begin
            if (reset_n[d] && rsp_valid[d]) begin
                if (sb[d].size() == 0) begin
                    check($sformatf("dut%0d unexpected rsp_valid", d), 32'(rsp_valid[d]), 32'h0);
                end else begin
                    exp_t e;
                    e = sb[d].pop_front();
                    check($sformatf("dut%0d rsp_rdata", d), rsp_rdata[d], e.rdata);
                    check($sformatf("dut%0d rsp_fault", d), 32'(rsp_fault[d]), 32'(e.fault));
                end
            end
        end
    end

    // Drives one request from a negedge, waits for acceptance, returns at the
    // negedge after the accept edge with req_valid dropped.
    task automatic issue(input int d, input vec_t v);
        int tries = 0;
        req_write[d]    = v.write;
        req_size[d]     = v.size;
        req_unsigned[d] = v.uns;
        req_addr[d]     = v.addr;
        req_wdata[d]    = v.wdata;
        req_valid[d]    = 1'b1;
        while (!req_ready[d] && tries < 50) begin
            @(negedge clock);
            tries++;
        end
        if (!req_ready[d]) begin
            fail_now($sformatf("dut%0d accept timeout", d));
            req_valid[d] = 1'b0;
            return;
        end
        sb[d].push_back('{rdata: v.exp_rdata, fault: v.exp_fault});
        @(negedge clock);
        req_valid[d] = 1'b0;
    endtask

    task automatic drain(input int d);
        int n = 0;
        while (sb[d].size() != 0 && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (sb[d].size() != 0) fail_now($sformatf("dut%0d response timeout", d));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] mis_w_rd, mis_h_rd;
        logic        mis_f;

        for (int d = 0; d < NDUT; d++) begin
            reset_n[d] = 1'b0; req_valid[d] = 1'b0; req_write[d] = 1'b0;
            req_size[d] = 2'd0; req_unsigned[d] = 1'b0;
            req_addr[d] = 32'h0; req_wdata[d] = 32'h0;
        end

`ifdef DMEM_MISALIGN_TRAP_EN
        mis_w_rd = 32'h0;        mis_h_rd = 32'h0;        mis_f = 1'b1;
`else
        mis_w_rd = 32'h8000_00F1; mis_h_rd = 32'hFFFF_CAFE; mis_f = 1'b0;
`endif

        //            wr    size     uns   addr          wdata          exp rdata      fault
        vecs.push_back(mk(1'b1, SZ_WORD, 1'b0, 32'h0000_0004, 32'h8000_00F1, 32'h0,         1'b0));
        vecs.push_back(mk(1'b0, SZ_WORD, 1'b0, 32'h0000_0004, 32'h0,         32'h8000_00F1, 1'b0));
        vecs.push_back(mk(1'b1, SZ_WORD, 1'b0, 32'h0000_0008, 32'h1122_3344, 32'h0,         1'b0));
        vecs.push_back(mk(1'b1, SZ_BYTE, 1'b0, 32'h0000_0009, 32'hFFFF_FFAB, 32'h0,         1'b0));
        vecs.push_back(mk(1'b0, SZ_BYTE, 1'b0, 32'h0000_0009, 32'h0,         32'hFFFF_FFAB, 1'b0));
        vecs.push_back(mk(1'b0, SZ_BYTE, 1'b1, 32'h0000_0009, 32'h0,         32'h0000_00AB, 1'b0));
        vecs.push_back(mk(1'b0, SZ_WORD, 1'b0, 32'h0000_0008, 32'h0,         32'h1122_AB44, 1'b0));
        vecs.push_back(mk(1'b1, SZ_WORD, 1'b0, 32'h0000_0000, 32'hCAFE_BABE, 32'h0,         1'b0));
        vecs.push_back(mk(1'b1, SZ_WORD, 1'b0, 32'h0000_0800, 32'hDEAD_BEEF, 32'h0,         1'b1));
        vecs.push_back(mk(1'b0, SZ_WORD, 1'b0, 32'h0000_0000, 32'h0,         32'hCAFE_BABE, 1'b0));
        vecs.push_back(mk(1'b0, SZ_RSVD, 1'b0, 32'h0000_0000, 32'h0,         32'h0,         1'b1));
        vecs.push_back(mk(1'b1, SZ_RSVD, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0,         1'b1));
        vecs.push_back(mk(1'b0, SZ_WORD, 1'b0, 32'h0000_0000, 32'h0,         32'hCAFE_BABE, 1'b0));
        vecs.push_back(mk(1'b0, SZ_HALF, 1'b0, 32'h0000_0002, 32'h0,         32'hFFFF_CAFE, 1'b0));
        vecs.push_back(mk(1'b0, SZ_HALF, 1'b1, 32'h0000_0002, 32'h0,         32'h0000_CAFE, 1'b0));
        vecs.push_back(mk(1'b0, SZ_WORD, 1'b0, 32'h0000_0006, 32'h0,         mis_w_rd,      mis_f));
        vecs.push_back(mk(1'b0, SZ_HALF, 1'b0, 32'h0000_0003, 32'h0,         mis_h_rd,      mis_f));
        vecs.push_back(mk(1'b1, SZ_HALF, 1'b0, 32'h0000_000A, 32'h9999_5678, 32'h0,         1'b0));
        vecs.push_back(mk(1'b0, SZ_WORD, 1'b0, 32'h0000_0008, 32'h0,         32'h5678_AB44, 1'b0));
        vecs.push_back(mk(1'b0, SZ_BYTE, 1'b0, 32'h0000_0004, 32'h0,         32'hFFFF_FFF1, 1'b0));
        vecs.push_back(mk(1'b0, SZ_BYTE, 1'b1, 32'h0000_0007, 32'h0,         32'h0000_0080, 1'b0));
        vecs.push_back(mk(1'b0, SZ_BYTE, 1'b0, 32'h0000_0007, 32'h0,         32'hFFFF_FF80, 1'b0));
        vecs.push_back(mk(1'b1, SZ_WORD, 1'b0, 32'h0000_07FC, 32'h0BAD_F00D, 32'h0,         1'b0));
        vecs.push_back(mk(1'b0, SZ_WORD, 1'b0, 32'h0000_07FC, 32'h0,         32'h0BAD_F00D, 1'b0));
        vecs.push_back(mk(1'b0, SZ_WORD, 1'b0, 32'hFFFF_FFFC, 32'h0,         32'h0,         1'b1));

        // Reset state of every instance
        @(negedge clock);
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("dut%0d reset rsp_valid", d), 32'(rsp_valid[d]), 32'h0);
            check($sformatf("dut%0d reset rsp_rdata", d), rsp_rdata[d], 32'h0);
            check($sformatf("dut%0d reset rsp_fault", d), 32'(rsp_fault[d]), 32'h0);
            check($sformatf("dut%0d reset req_ready", d), 32'(req_ready[d]), 32'h1);
        end
        @(negedge clock);
        for (int d = 0; d < NDUT; d++) reset_n[d] = 1'b1;
        @(negedge clock);

        // Vector table on the zero-wait instance, back to back: each response
        // must appear in the cycle right after its accept edge.
        for (int i = 0; i < vecs.size(); i++) begin
            issue(0, vecs[i]);
            check($sformatf("dut0 vec%0d rsp_valid next cycle", i), 32'(rsp_valid[0]), 32'h1);
        end
        drain(0);

        // Latency with three wait states; request fields are scrambled while
        // waiting and must be ignored.
        issue(1, mk(1'b1, SZ_WORD, 1'b0, 32'h0000_0020, 32'h1357_9BDF, 32'h0, 1'b0));
        drain(1);
        req_write[1] = 1'b0; req_size[1] = SZ_WORD; req_unsigned[1] = 1'b0;
        req_addr[1]  = 32'h0000_0020; req_wdata[1] = 32'h0; req_valid[1] = 1'b1;
        check("dut1 ready at accept", 32'(req_ready[1]), 32'h1);
        sb[1].push_back('{rdata: 32'h1357_9BDF, fault: 1'b0});
        @(negedge clock);
        req_valid[1] = 1'b0; req_write[1] = 1'b1; req_addr[1] = 32'h0000_0004;
        req_wdata[1] = 32'hFFFF_FFFF; req_size[1] = SZ_BYTE;
        for (int k = 1; k <= 3; k++) begin
            check($sformatf("dut1 ready t+%0d", k), 32'(req_ready[1]), 32'h0);
            check($sformatf("dut1 rsp_valid t+%0d", k), 32'(rsp_valid[1]), 32'h0);
            @(negedge clock);
        end
        check("dut1 rsp_valid t+4", 32'(rsp_valid[1]), 32'h1);
        check("dut1 ready t+4", 32'(req_ready[1]), 32'h1);
        req_write[1] = 1'b0;
        @(negedge clock);
        drain(1);

        // Reset while a store is waiting: no response, store discarded.
        issue(2, mk(1'b1, SZ_WORD, 1'b0, 32'h0000_0010, 32'hA5A5_0001, 32'h0, 1'b0));
        drain(2);
        req_write[2] = 1'b1; req_size[2] = SZ_WORD; req_unsigned[2] = 1'b0;
        req_addr[2]  = 32'h0000_0010; req_wdata[2] = 32'h0000_1234; req_valid[2] = 1'b1;
        @(negedge clock);
        req_valid[2] = 1'b0; req_write[2] = 1'b0;
        check("dut2 in WAIT before reset", 32'(req_ready[2]), 32'h0);
        reset_n[2] = 1'b0;
        #1;
        check("dut2 ready during reset", 32'(req_ready[2]), 32'h1);
        check("dut2 rsp_valid during reset", 32'(rsp_valid[2]), 32'h0);
        check("dut2 rsp_rdata during reset", rsp_rdata[2], 32'h0);
        @(negedge clock);
        @(negedge clock);
        reset_n[2] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check($sformatf("dut2 no rsp after reset %0d", k), 32'(rsp_valid[2]), 32'h0);
        end
        issue(2, mk(1'b0, SZ_WORD, 1'b0, 32'h0000_0010, 32'h0, 32'hA5A5_0001, 1'b0));
        drain(2);

        repeat (3) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
